// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: accumulates credit from coin pulses,
// vends on sel when credit covers PRICE, and returns change or refunds on cancel.
module vend_ctrl #(
  parameter logic [6:0] PRICE      = 7'd35,
  parameter logic [6:0] MAX_CREDIT = 7'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       coin20,
  input  logic       sel,
  input  logic       cancel,
  output logic [6:0] credit,
  output logic       dispense,
  output logic       change_valid,
  output logic [6:0] change_amt,
  output logic       coin_reject,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  state_t     state, next_state;
  logic [6:0] refund_amt, next_refund;
  logic [6:0] next_credit, next_change_amt;
  logic       next_dispense, next_change_valid, next_coin_reject;
  logic       any_coin;
  logic [7:0] coin_sum, credit_total;

  // 8-bit sum so credit + coins can be compared to the ceiling without wrapping
  assign any_coin     = coin5 | coin10 | coin20;
  assign coin_sum     = (coin5  ? 8'd5  : 8'd0) +
                        (coin10 ? 8'd10 : 8'd0) +
                        (coin20 ? 8'd20 : 8'd0);
  assign credit_total = {1'b0, credit} + coin_sum;

  assign busy      = (state == VEND) || (state == REFUND);
  assign state_dbg = state;

  always_comb begin
    next_state        = state;
    next_credit       = credit;
    next_refund       = refund_amt;
    next_dispense     = 1'b0;
    next_change_valid = 1'b0;
    next_change_amt   = 7'd0;
    next_coin_reject  = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel && (credit != 7'd0)) begin
          next_state        = REFUND;
          next_refund       = credit;
          next_change_valid = 1'b1;
          next_change_amt   = credit;
          next_coin_reject  = any_coin;
        end else if (sel && (credit >= PRICE)) begin
          next_state       = VEND;
          next_refund      = credit - PRICE;
          next_dispense    = 1'b1;
          next_coin_reject = any_coin;
        end else if (any_coin) begin
          if (credit_total <= {1'b0, MAX_CREDIT}) begin
            next_credit = credit_total[6:0];
            next_state  = COLLECT;
          end else begin
            next_coin_reject = 1'b1;
          end
        end
      end
      VEND: begin
        // Outputs are registered, so REFUND's change pulse is loaded on leaving VEND
        next_state        = REFUND;
        next_change_valid = (refund_amt != 7'd0);
        next_change_amt   = refund_amt;
        next_coin_reject  = any_coin;
      end
      REFUND: begin
        next_state       = IDLE;
        next_credit      = 7'd0;
        next_refund      = 7'd0;
        next_coin_reject = any_coin;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      credit       <= 7'd0;
      refund_amt   <= 7'd0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= 7'd0;
      coin_reject  <= 1'b0;
    end else begin
      state        <= next_state;
      credit       <= next_credit;
      refund_amt   <= next_refund;
      dispense     <= next_dispense;
      change_valid <= next_change_valid;
      change_amt   <= next_change_amt;
      coin_reject  <= next_coin_reject;
    end
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 7'd35, item price in cents.
REQ-002 SHALL have parameter MAX_CREDIT, default 7'd100, credit ceiling in cents.
REQ-003 SHALL have port clk input 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-005 SHALL have port coin5 input 1: single-cycle 5-cent coin pulse from the upstream debounce stage.
REQ-006 SHALL have port coin10 input 1: single-cycle 10-cent coin pulse from the upstream debounce stage.
REQ-007 SHALL have port coin20 input 1: single-cycle 20-cent coin pulse from the upstream debounce stage.
REQ-008 SHALL have port sel input 1: single-cycle vend-request pulse from the upstream debounce stage.
REQ-009 SHALL have port cancel input 1: single-cycle refund-request pulse from the upstream debounce stage.
REQ-010 SHALL have port credit output 7: current accumulated credit in cents, registered.
REQ-011 SHALL have port dispense output 1: one-cycle vend pulse, registered.
REQ-012 SHALL have port change_valid output 1: one-cycle pulse qualifying change_amt, registered.
REQ-013 SHALL have port change_amt output 7: amount returned, valid only while change_valid=1, registered.
REQ-014 SHALL have port coin_reject output 1: one-cycle pulse, registered, asserted when a coin is not accepted.
REQ-015 SHALL have port busy output 1: high in states VEND and REFUND.

Function
REQ-016 SHALL implement the states IDLE (credit=0), COLLECT (credit>0), VEND and REFUND.
REQ-017 SHALL evaluate requests in IDLE/COLLECT with the priority cancel > sel > coins.
REQ-018 SHALL, on cancel with credit>0, go to REFUND with refund amount = credit.
REQ-019 SHALL ignore cancel when credit=0.
REQ-020 SHALL, on sel with credit>=PRICE, go to VEND with refund amount = credit-PRICE.
REQ-021 SHALL ignore sel with credit<PRICE: no output pulse, state unchanged.
REQ-022 SHALL treat coin pulses arriving in the same cycle as an accepted cancel or sel as rejected: coin_reject=1 for one cycle and credit is not updated.
REQ-023 SHALL, for coin pulses without a higher-priority event, compute sum = 5*coin5 + 10*coin10 + 20*coin20, with simultaneous coins summed.
REQ-024 SHALL, if credit+sum<=MAX_CREDIT, set credit <= credit+sum and move to COLLECT.
REQ-025 SHALL otherwise accept none of the coins in that cycle: coin_reject pulses and credit is unchanged.
REQ-026 SHALL use 8-bit internal addition so that credit+sum never wraps.
REQ-027 SHALL, in VEND (exactly 1 cycle), drive dispense=1 and move to REFUND.
REQ-028 SHALL, in REFUND (exactly 1 cycle), drive change_valid=1 and change_amt=refund amount if that amount is nonzero.
REQ-029 SHALL, in REFUND with a zero refund amount, keep change_valid=0 and change_amt=0.
REQ-030 SHALL clear credit to 0 and return to IDLE at the end of REFUND.
REQ-031 SHALL, in VEND and REFUND, reject every coin pulse with coin_reject and ignore sel and cancel.
REQ-032 SHALL give latency of 1 cycle from sampled sel to dispense, and 1 further cycle to change_valid.
REQ-033 SHALL give latency of 1 cycle from sampled cancel to change_valid.
REQ-034 SHALL update credit 1 cycle after the coin pulse is sampled.
REQ-035 SHALL hold change_amt at 0 whenever change_valid=0.

Reset
REQ-036 SHALL, on rst_n low, immediately force state=IDLE, credit=0, dispense=0, change_valid=0, change_amt=0, coin_reject=0, busy=0 regardless of clk.
REQ-037 SHALL, on reset in mid-VEND or mid-REFUND, discard the pending refund amount and emit no pulse after release.
REQ-038 SHALL resume normal operation on the first posedge clk after rst_n rises.

Verification
REQ-039 Bench SHALL cover: coin20, coin10, coin5, then sel (PRICE=35) -> credit reaches 35; dispense 1 cycle after sel; next cycle change_valid=0; credit=0.
REQ-040 Bench SHALL cover: coin20 x2, then sel -> dispense, then change_valid=1 with change_amt=5; IDLE after.
REQ-041 Bench SHALL cover: credit 30, then cancel -> change_valid=1 with change_amt=30 1 cycle later; no dispense.
REQ-042 Bench SHALL cover: credit 90, then coin10 and coin5 in the same cycle -> coin_reject=1 and credit stays 90; then coin10 alone -> credit=100.
REQ-043 Bench SHALL cover: credit 35, then sel, cancel and coin5 in the same cycle -> change_valid with change_amt=35, coin_reject=1, no dispense.
REQ-044 Bench SHALL cover: rst_n low asynchronously during VEND -> all outputs 0 immediately; no change_valid after release; coin5 after release -> credit=5.
